// File: rtl/mult_pkg.sv
// Shared types and width constant for the signed add-shift multiplier.
package mult_pkg;
    localparam int WIDTH = 8;
    typedef logic [WIDTH-1:0] operand_t;
    typedef logic [WIDTH:0]   ext_t;
endpackage

// File: rtl/mult_datapath_if.sv
// Strobe and result bundle between the multiplier control unit and datapath.
interface mult_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   S;
    logic               Clr_Ld;
    logic               ClearA;
    logic               Add;
    logic               Sub;
    logic               Shift;
    logic [WIDTH-1:0]   Bin;
    logic [WIDTH-1:0]   Aval;
    logic               X;
    logic [2*WIDTH-1:0] Product;
    logic               Err;

    modport master (
        output S, Clr_Ld, ClearA, Add, Sub, Shift,
        input  Bin, Aval, X, Product, Err
    );

    modport slave (
        input  S, Clr_Ld, ClearA, Add, Sub, Shift,
        output Bin, Aval, X, Product, Err
    );
endinterface

// File: rtl/mult_datapath_adder9.sv
// Sign-extending ripple adder/subtractor, WIDTH+1 bits, carry out dropped.
module adder9 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] s,
    input  logic             sub,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic           carry;

    always_comb begin
        a_x   = {a[WIDTH-1], a};
        b_x   = {s[WIDTH-1], s} ^ {(WIDTH+1){sub}};
        carry = sub;
        sum   = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            sum[i] = a_x[i] ^ b_x[i] ^ carry;
            carry  = (a_x[i] & b_x[i]) | (carry & (a_x[i] ^ b_x[i]));
        end
    end
endmodule

// File: rtl/mult_datapath.sv
// A/B/X register datapath of the 8-bit signed add-shift multiplier.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    mult_datapath_if.slave   dp
);
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             x_q;
    logic             err_q;
    logic [WIDTH:0]   sum;
    logic             arith;
    logic             do_shift;
    logic             illegal;

    adder9 #(.WIDTH(WIDTH)) u_adder (
        .a   (a_q),
        .s   (dp.S),
        .sub (dp.Sub),
        .sum (sum)
    );

    assign arith    = dp.Add | dp.Sub;
    assign do_shift = dp.Shift & ~arith;
    assign illegal  = (dp.Add & dp.Sub) | (dp.Add & dp.Shift)
                    | (dp.Sub & dp.Shift) | (arith & dp.ClearA);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            x_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (dp.Clr_Ld)
                b_q <= dp.S;
            else if (do_shift)
                b_q <= {a_q[0], b_q[WIDTH-1:1]};

            if (dp.ClearA) begin
                a_q <= '0;
                x_q <= 1'b0;
            end else if (arith) begin
                {x_q, a_q} <= sum;
            end else if (do_shift) begin
                a_q <= {x_q, a_q[WIDTH-1:1]};
            end

            // A new illegal combination outranks the clear from ClearA.
            if (illegal)
                err_q <= 1'b1;
            else if (dp.ClearA)
                err_q <= 1'b0;
        end
    end

    assign dp.Bin     = b_q;
    assign dp.Aval    = a_q;
    assign dp.X       = x_q;
    assign dp.Product = {a_q, b_q};
    assign dp.Err     = err_q;
endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath.
module tb_mult_datapath;
    import mult_pkg::*;

    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;

    mult_datapath_if #(.WIDTH(WIDTH)) dp ();

    mult_datapath #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .dp      (dp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        dp.Clr_Ld = 0;
        dp.ClearA = 0;
        dp.Add    = 0;
        dp.Sub    = 0;
        dp.Shift  = 0;
    endtask

    task automatic test_reset();
        dp.S = 8'hAA;
        dp.Clr_Ld = 1;
        cyc();
        idle();
        checks++;
        if (dp.Bin !== 8'hAA) begin
            errors++;
            $display("FAIL pre_reset_load B=%h want AA", dp.Bin);
        end
        #3;
        Reset_n = 0;
        #1;
        checks++;
        if (dp.Aval !== 8'h00 || dp.Bin !== 8'h00 ||
            dp.X !== 1'b0 || dp.Err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset A=%h B=%h X=%b Err=%b want 0",
                     dp.Aval, dp.Bin, dp.X, dp.Err);
        end
        cyc();
        Reset_n = 1;
        cyc();
    endtask

    task automatic test_load();
        dp.S = 8'h07;
        dp.Clr_Ld = 1;
        dp.ClearA = 1;
        cyc();
        idle();
        checks++;
        if (dp.Bin !== 8'h07 || dp.Aval !== 8'h00 || dp.X !== 1'b0) begin
            errors++;
            $display("FAIL load B=%h A=%h X=%b want 07 00 0",
                     dp.Bin, dp.Aval, dp.X);
        end
        cyc();
        checks++;
        if (dp.Bin !== 8'h07 || dp.Aval !== 8'h00) begin
            errors++;
            $display("FAIL idle_hold B=%h A=%h want 07 00",
                     dp.Bin, dp.Aval);
        end
    endtask

    task automatic test_add_shift();
        dp.S = 8'hFD;
        dp.Add = 1;
        cyc();
        idle();
        checks++;
        if (dp.Aval !== 8'hFD || dp.X !== 1'b1 || dp.Bin !== 8'h07) begin
            errors++;
            $display("FAIL add_neg A=%h X=%b B=%h want FD 1 07",
                     dp.Aval, dp.X, dp.Bin);
        end
        dp.Shift = 1;
        cyc();
        idle();
        checks++;
        if (dp.Aval !== 8'hFE || dp.Bin !== 8'h83 || dp.X !== 1'b1) begin
            errors++;
            $display("FAIL shift A=%h B=%h X=%b want FE 83 1",
                     dp.Aval, dp.Bin, dp.X);
        end
    endtask

    task automatic test_sub_overflow();
        dp.ClearA = 1;
        cyc();
        idle();
        dp.S = 8'h80;
        dp.Sub = 1;
        cyc();
        idle();
        checks++;
        if (dp.Aval !== 8'h80 || dp.X !== 1'b0) begin
            errors++;
            $display("FAIL sub_ovf A=%h X=%b want 80 0", dp.Aval, dp.X);
        end
        dp.ClearA = 1;
        cyc();
        idle();
        dp.S = 8'h7F;
        dp.Add = 1;
        cyc();
        dp.S = 8'h80;
        cyc();
        idle();
        checks++;
        if (dp.Aval !== 8'hFF || dp.X !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf A=%h X=%b want FF 1", dp.Aval, dp.X);
        end
        checks++;
        if (dp.Err !== 1'b0) begin
            errors++;
            $display("FAIL err_legal Err=%b want 0", dp.Err);
        end
    endtask

    task automatic run_mul(input operand_t b, input operand_t s,
                           input logic [15:0] exp_p, input logic exp_x);
        dp.S = b;
        dp.Clr_Ld = 1;
        dp.ClearA = 1;
        cyc();
        idle();
        dp.S = s;
        for (int i = 0; i < 8; i++) begin
            if (dp.Bin[0]) begin
                if (i == 7) dp.Sub = 1;
                else        dp.Add = 1;
                cyc();
                idle();
            end
            dp.Shift = 1;
            cyc();
            idle();
        end
        checks++;
        if (dp.Product !== exp_p || dp.X !== exp_x) begin
            errors++;
            $display("FAIL mul_%h_%h P=%h X=%b want %h %b",
                     b, s, dp.Product, dp.X, exp_p, exp_x);
        end
    endtask

    task automatic test_multiply();
        run_mul(8'h07, 8'hFD, 16'hFFEB, 1'b1);
        run_mul(8'h07, 8'h03, 16'h0015, 1'b0);
        run_mul(8'h80, 8'h80, 16'h4000, 1'b0);
        run_mul(8'hFF, 8'hFF, 16'h0001, 1'b0);
    endtask

    task automatic test_illegal();
        dp.S = 8'h55;
        dp.Clr_Ld = 1;
        dp.ClearA = 1;
        cyc();
        idle();
        dp.S = 8'h01;
        dp.Add = 1;
        cyc();
        dp.Shift = 1;
        cyc();
        idle();
        checks++;
        if (dp.Aval !== 8'h02 || dp.Bin !== 8'h55 || dp.Err !== 1'b1) begin
            errors++;
            $display("FAIL add_shift A=%h B=%h Err=%b want 02 55 1",
                     dp.Aval, dp.Bin, dp.Err);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (dp.Err !== 1'b1) begin
                errors++;
                $display("FAIL err_hold%0d Err=%b want 1", i, dp.Err);
            end
        end
        dp.ClearA = 1;
        cyc();
        idle();
        checks++;
        if (dp.Err !== 1'b0 || dp.Aval !== 8'h00) begin
            errors++;
            $display("FAIL err_clear Err=%b A=%h want 0 00",
                     dp.Err, dp.Aval);
        end
        dp.S = 8'h01;
        dp.ClearA = 1;
        dp.Add = 1;
        cyc();
        idle();
        checks++;
        if (dp.Err !== 1'b1 || dp.Aval !== 8'h00) begin
            errors++;
            $display("FAIL clr_add Err=%b A=%h want 1 00",
                     dp.Err, dp.Aval);
        end
        dp.S = 8'h03;
        dp.Sub = 1;
        dp.Add = 1;
        dp.ClearA = 1;
        cyc();
        idle();
        dp.ClearA = 1;
        cyc();
        idle();
        dp.Sub = 1;
        dp.Add = 1;
        cyc();
        idle();
        checks++;
        if (dp.Aval !== 8'hFD || dp.X !== 1'b1 || dp.Err !== 1'b1) begin
            errors++;
            $display("FAIL sub_wins A=%h X=%b Err=%b want FD 1 1",
                     dp.Aval, dp.X, dp.Err);
        end
    endtask

    task automatic test_reset_midop();
        dp.S = 8'h5A;
        dp.Clr_Ld = 1;
        dp.ClearA = 1;
        cyc();
        idle();
        dp.S = 8'hF0;
        dp.Add = 1;
        cyc();
        #2;
        Reset_n = 0;
        #1;
        checks++;
        if (dp.Product !== 16'h0000 || dp.X !== 1'b0 || dp.Err !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset P=%h X=%b Err=%b want 0000 0 0",
                     dp.Product, dp.X, dp.Err);
        end
        cyc();
        checks++;
        if (dp.Aval !== 8'h00) begin
            errors++;
            $display("FAIL reset_held A=%h want 00", dp.Aval);
        end
        Reset_n = 1;
        cyc();
        idle();
        checks++;
        if (dp.Aval !== 8'hF0 || dp.X !== 1'b1) begin
            errors++;
            $display("FAIL resume A=%h X=%b want F0 1", dp.Aval, dp.X);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        Reset_n = 0;
        dp.S    = '0;
        idle();
        cyc();
        cyc();
        Reset_n = 1;
        cyc();
        test_reset();
        test_load();
        test_add_shift();
        test_sub_overflow();
        test_multiply();
        test_illegal();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
